// File: rtl/prbs16_checker.sv
// Receive-side PRBS16 (x^16+x^14+x^13+x^11+1) checker: self-synchronises to the stream,
// then flywheels the local LFSR, flags and counts bit errors, and drops lock on error bursts.
module prbs16_checker #(
    parameter int unsigned LOCK_COUNT  = 32,
    parameter int unsigned LOSS_ERRORS = 4,
    parameter int unsigned LOSS_WINDOW = 64
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        din_i,
    input  logic        din_valid_i,
    input  logic        err_clr_i,
    output logic        locked_o,
    output logic        err_pulse_o,
    output logic [15:0] err_count_o
);

    typedef enum logic [1:0] {StFill, StVerify, StLocked} state_e;

    state_e      state_q, state_d;
    logic [15:0] s_q, s_d;
    logic [3:0]  fill_cnt_q, fill_cnt_d;
    logic [7:0]  good_cnt_q, good_cnt_d;
    logic [9:0]  win_cnt_q, win_cnt_d;
    logic [9:0]  win_err_q, win_err_d;
    logic        locked_q, locked_d;
    logic        err_pulse_q, err_pulse_d;
    logic [15:0] err_count_q, err_count_d;

    logic        pred;
    logic        mism;
    logic [9:0]  win_err_inc;

    assign pred        = s_q[15] ^ s_q[13] ^ s_q[12] ^ s_q[10];
    assign mism        = din_i ^ pred;
    assign win_err_inc = win_err_q + {9'd0, mism};

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        fill_cnt_d  = fill_cnt_q;
        good_cnt_d  = good_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;

        if (din_valid_i) begin
            unique case (state_q)
                StFill: begin
                    s_d = {s_q[14:0], din_i};
                    if (fill_cnt_q == 4'd15) begin
                        fill_cnt_d = 4'd0;
                        good_cnt_d = 8'd0;
                        state_d    = StVerify;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 4'd1;
                    end
                end
                StVerify: begin
                    s_d = {s_q[14:0], din_i};
                    // An all-zero history is the LFSR lock-up state, never a valid match.
                    if (!mism && (s_q != 16'd0)) begin
                        good_cnt_d = good_cnt_q + 8'd1;
                        if (good_cnt_q + 8'd1 == 8'(LOCK_COUNT)) begin
                            win_cnt_d = 10'd0;
                            win_err_d = 10'd0;
                            state_d   = StLocked;
                        end
                    end else begin
                        good_cnt_d = 8'd0;
                    end
                end
                StLocked: begin
                    // Flywheel: the local LFSR ignores received bits so one flip counts once.
                    s_d = {s_q[14:0], pred};
                    if (mism) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != 16'hFFFF) begin
                            err_count_d = err_count_q + 16'd1;
                        end
                    end
                    if (win_err_inc == 10'(LOSS_ERRORS)) begin
                        fill_cnt_d = 4'd0;
                        state_d    = StFill;
                    end else if (win_cnt_q == 10'(LOSS_WINDOW - 1)) begin
                        win_cnt_d = 10'd0;
                        win_err_d = 10'd0;
                    end else begin
                        win_cnt_d = win_cnt_q + 10'd1;
                        win_err_d = win_err_inc;
                    end
                end
                default: state_d = StFill;
            endcase
        end

        if (err_clr_i) begin
            err_count_d = 16'd0;
        end
        locked_d = (state_d == StLocked);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StFill;
            s_q         <= 16'd0;
            fill_cnt_q  <= 4'd0;
            good_cnt_q  <= 8'd0;
            win_cnt_q   <= 10'd0;
            win_err_q   <= 10'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            fill_cnt_q  <= fill_cnt_d;
            good_cnt_q  <= good_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked_o    = locked_q;
    assign err_pulse_o = err_pulse_q;
    assign err_count_o = err_count_q;

endmodule
